// File: rtl/video_pkg.sv
// Shared timing description for the raster generator: mode record, standard
// modes and helpers that derive totals and sync windows from a mode.
package video_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } timing_t;

  localparam timing_t VGA_640x480 = '{32'd640, 32'd16, 32'd96, 32'd48,
                                      32'd480, 32'd10, 32'd2,  32'd33};
  localparam timing_t SVGA_800x600 = '{32'd800, 32'd40, 32'd128, 32'd88,
                                       32'd600, 32'd1,  32'd4,   32'd23};

  function automatic int unsigned h_total(input timing_t t);
    return t.h_active + t.h_front + t.h_sync + t.h_back;
  endfunction

  function automatic int unsigned v_total(input timing_t t);
    return t.v_active + t.v_front + t.v_sync + t.v_back;
  endfunction

  function automatic int unsigned h_sync_begin(input timing_t t);
    return t.h_active + t.h_front;
  endfunction

  function automatic int unsigned h_sync_end(input timing_t t);
    return t.h_active + t.h_front + t.h_sync;
  endfunction

  function automatic int unsigned v_sync_begin(input timing_t t);
    return t.v_active + t.v_front;
  endfunction

  function automatic int unsigned v_sync_end(input timing_t t);
    return t.v_active + t.v_front + t.v_sync;
  endfunction

endpackage

// File: rtl/video_delay.sv
// Enable-gated shift register used to realign control bits with the pixel
// source latency; a depth of zero degenerates to a plain wire.
module video_delay #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one place per enabled dot, idle pattern on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_r[i] <= RESET_VALUE;
      end else if (enable) begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: dot/line counters, fetch coordinates and strobes,
// plus an output stage that realigns sync/blank with the returned RGB.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0,
  parameter int          PIPE_DELAY = 2,
  parameter int          X_WIDTH    = 11,
  parameter int          Y_WIDTH    = 10
) (
  input  logic               inp_clock,
  input  logic               inp_reset,
  input  logic               inp_enable,
  input  logic [7:0]         inp_red,
  input  logic [7:0]         inp_green,
  input  logic [7:0]         inp_blue,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y,
  output logic               out_fetch,
  output logic               out_line_start,
  output logic               out_frame_start,
  output logic [7:0]         out_red,
  output logic [7:0]         out_green,
  output logic [7:0]         out_blue,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_blank,
  output logic               out_clock
);

  localparam timing_t     TIM     = '{H_ACTIVE, H_FRONT, H_SYNC, H_BACK,
                                      V_ACTIVE, V_FRONT, V_SYNC, V_BACK};
  localparam int unsigned H_TOTAL = h_total(TIM);
  localparam int unsigned V_TOTAL = v_total(TIM);

  if (X_WIDTH == 0 || Y_WIDTH == 0 || H_ACTIVE == 0 || H_FRONT == 0 ||
      H_SYNC == 0 || H_BACK == 0 || V_ACTIVE == 0 || V_FRONT == 0 ||
      V_SYNC == 0 || V_BACK == 0) begin : g_bad_width
    $error("video_timing: width parameters must be non-zero");
  end
  if (((64'(H_TOTAL) - 64'd1) >> X_WIDTH) != 64'd0) begin : g_bad_x
    $error("video_timing: H_TOTAL-1 does not fit in X_WIDTH");
  end
  if (((64'(V_TOTAL) - 64'd1) >> Y_WIDTH) != 64'd0) begin : g_bad_y
    $error("video_timing: V_TOTAL-1 does not fit in Y_WIDTH");
  end

  localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] X_ACTIVE = X_WIDTH'(H_ACTIVE);
  localparam logic [Y_WIDTH-1:0] Y_ACTIVE = Y_WIDTH'(V_ACTIVE);
  localparam logic [X_WIDTH-1:0] HS_BEG   = X_WIDTH'(h_sync_begin(TIM));
  localparam logic [X_WIDTH-1:0] HS_END   = X_WIDTH'(h_sync_end(TIM));
  localparam logic [Y_WIDTH-1:0] VS_BEG   = Y_WIDTH'(v_sync_begin(TIM));
  localparam logic [Y_WIDTH-1:0] VS_END   = Y_WIDTH'(v_sync_end(TIM));

  logic [X_WIDTH-1:0] x_r;
  logic [Y_WIDTH-1:0] y_r;
  logic               active_s;
  logic               hsync_s;
  logic               vsync_s;
  logic [2:0]         delayed_s;

  // Dot and line counters with frame wrap.
  always_ff @(posedge inp_clock or negedge inp_reset) begin
    if (!inp_reset) begin
      x_r <= '0;
      y_r <= '0;
    end else if (inp_enable) begin
      if (x_r == X_LAST) begin
        x_r <= '0;
        y_r <= (y_r == Y_LAST) ? '0 : y_r + 1'b1;
      end else begin
        x_r <= x_r + 1'b1;
      end
    end
  end

  // Stage-0 decode; vsync depends on the line only, not on the dot.
  always_comb begin
    active_s = (x_r < X_ACTIVE) && (y_r < Y_ACTIVE);
    hsync_s  = ((x_r >= HS_BEG) && (x_r < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_s  = ((y_r >= VS_BEG) && (y_r < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  video_delay #(
    .WIDTH       (3),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE ({1'b0, ~H_SYNC_POL, ~V_SYNC_POL})
  ) u_delay (
    .clk    (inp_clock),
    .rst_n  (inp_reset),
    .enable (inp_enable),
    .din    ({active_s, hsync_s, vsync_s}),
    .dout   (delayed_s)
  );

  // Output register: RGB is blanked whenever the realigned dot is inactive.
  always_ff @(posedge inp_clock or negedge inp_reset) begin
    if (!inp_reset) begin
      out_blank <= 1'b0;
      out_hsync <= ~H_SYNC_POL;
      out_vsync <= ~V_SYNC_POL;
      out_red   <= 8'd0;
      out_green <= 8'd0;
      out_blue  <= 8'd0;
    end else if (inp_enable) begin
      out_blank <= delayed_s[2];
      out_hsync <= delayed_s[1];
      out_vsync <= delayed_s[0];
      out_red   <= delayed_s[2] ? inp_red   : 8'd0;
      out_green <= delayed_s[2] ? inp_green : 8'd0;
      out_blue  <= delayed_s[2] ? inp_blue  : 8'd0;
    end
  end

  assign out_x           = x_r;
  assign out_y           = y_r;
  assign out_fetch       = active_s;
  assign out_line_start  = inp_enable && (x_r == '0);
  assign out_frame_start = out_line_start && (y_r == '0);
  assign out_clock       = inp_clock;

endmodule

// File: tb/tb_video_timing.sv
// Randomised bench for video_timing on a small mode: a dot-index model derives
// every expected counter, strobe, sync, blank and RGB value.
module tb_video_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int D = 2;
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b0;
  localparam int N_CYCLES = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  ri, gi, bi;
  logic [10:0] ox;
  logic [9:0]  oy;
  logic        fetch, ls, fs, hs, vs, blank, oclk;
  logic [7:0]  ro, go, bo;

  int n_checks = 0;
  int n_fail   = 0;
  int k;
  int rst_hold = 0;

  always #5 clk = ~clk;

  video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .PIPE_DELAY(D),
    .X_WIDTH(11), .Y_WIDTH(10)
  ) dut (
    .inp_clock(clk), .inp_reset(rst_n), .inp_enable(en),
    .inp_red(ri), .inp_green(gi), .inp_blue(bi),
    .out_x(ox), .out_y(oy), .out_fetch(fetch),
    .out_line_start(ls), .out_frame_start(fs),
    .out_red(ro), .out_green(go), .out_blue(bo),
    .out_hsync(hs), .out_vsync(vs), .out_blank(blank), .out_clock(oclk)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic logic [23:0] src_rgb(input int x, input int y);
    logic [7:0] b;
    b = 8'(x * 3 + y * 5) ^ 8'h5A;
    return {x[7:0], y[7:0], b};
  endfunction

  task automatic check_outputs();
    int cx, cy, px, py, idx;
    logic act, hact, vact;
    logic [2:0]  exp_sync;
    logic [23:0] exp_rgb;
    cx = (k % FRAME) % HT;
    cy = (k % FRAME) / HT;
    check_eq("coord", 32'({oy, ox}), 32'({cy[9:0], cx[10:0]}));
    check_eq("strobes", 32'({fetch, ls, fs}),
             32'({(cx < HA && cy < VA), (en && cx == 0), (en && cx == 0 && cy == 0)}));
    if (k >= D + 1) begin
      idx  = (k - 1 - D) % FRAME;
      px   = idx % HT;
      py   = idx / HT;
      act  = (px < HA) && (py < VA);
      hact = (px >= HA + HF) && (px < HA + HF + HS);
      vact = (py >= VA + VF) && (py < VA + VF + VS);
      exp_sync = {act, hact ? HPOL : ~HPOL, vact ? VPOL : ~VPOL};
      exp_rgb  = act ? src_rgb(px, py) : 24'd0;
    end else begin
      exp_sync = {1'b0, ~HPOL, ~VPOL};
      exp_rgb  = 24'd0;
    end
    check_eq("blank_sync", 32'({blank, hs, vs}), 32'(exp_sync));
    check_eq("rgb", 32'({ro, go, bo}), 32'(exp_rgb));
    check_eq("clock", 32'(oclk), 32'(clk));
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    en    = 1'b0;
    {ri, gi, bi} = 24'($urandom);
    k = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      if (rst_n && en) k++;
      #1;
      if (cyc < FRAME + 40)          en = 1'b1;
      else if (cyc < 3 * FRAME + 40) en = cyc[0];
      else                           en = ($urandom_range(0, 3) != 0);

      if (k >= D) begin
        idx = (k - D) % FRAME;
        {ri, gi, bi} = en ? src_rgb(idx % HT, idx / HT) : 24'($urandom);
      end else begin
        {ri, gi, bi} = 24'($urandom);
      end

      if (cyc == 0) begin
        rst_n = 1'b1;
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (cyc == 1500 || (cyc > 600 && $urandom_range(0, 499) == 0)) begin
        #1;
        rst_n    = 1'b0;
        k        = 0;
        rst_hold = $urandom_range(1, 3);
      end

      @(negedge clk);
      check_outputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Parametrised raster timing generator and pixel-output stage for the video path. Generates horizontal/vertical dot counters and pixel-fetch coordinates for an upstream pixel source, then realigns HSYNC, VSYNC and BLANK with that source's returned RGB through a configurable-latency delay line. Adds per-mode timing, sync polarity, a dot-clock enable and line/frame strobes. Drives the external video DAC/encoder.

## Interface
- H_ACTIVE, 640, visible dots per line
- H_FRONT, 16, horizontal front porch (dots)
- H_SYNC, 96, horizontal sync width (dots)
- H_BACK, 48, horizontal back porch (dots)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of out_hsync
- V_SYNC_POL, 0, asserted level of out_vsync
- PIPE_DELAY, 2, cycles from out_x/out_y to matching inp_red/green/blue (0 = combinational source)
- X_WIDTH, 11; Y_WIDTH, 10, counter widths
- inp_clock  in  1  system/dot clock
- inp_reset  in  1  reset; one clock; reset is asynchronous and active-low
- inp_enable  in  1  dot tick; all state advances only when high
- inp_red, inp_green, inp_blue  in  8 each  pixel data from source
- out_x  out  X_WIDTH  current horizontal dot counter
- out_y  out  Y_WIDTH  current line counter
- out_fetch  out  1  high when (out_x, out_y) is in the active area
- out_line_start  out  1  pulse, out_x == 0 and inp_enable
- out_frame_start  out  1  pulse, out_x == 0, out_y == 0 and inp_enable
- out_red, out_green, out_blue  out  8 each  aligned pixel data
- out_hsync, out_vsync  out  1  aligned sync
- out_blank  out  1  aligned display-enable: 1 = active pixel, 0 = blanking
- out_clock  out  1  equals inp_clock

## Operation
- H_TOTAL = sum of H_* widths (800); V_TOTAL = sum of V_* widths (525).
- On enabled cycles: x increments; at H_TOTAL-1, x -> 0 and y increments; at x = H_TOTAL-1 and y = V_TOTAL-1, both -> 0.
- Stage-0 decode from counters: active = x < H_ACTIVE && y < V_ACTIVE; hsync asserted for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); vsync asserted for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), decoded from y only.
- {active, hsync, vsync} pass through a PIPE_DELAY-deep delay line that shifts only on enable, then a final output register that also captures inp_rgb. RGB is forced to 0 when the delayed active bit is 0, regardless of inputs.
- out_fetch, out_line_start and out_frame_start are combinational decodes of the counter registers (strobes gated by inp_enable).
- inp_enable low: counters, delay line and output registers hold; strobes are 0.
- Reset (asynchronous, immediate): x = y = 0; delay line and outputs at idle: out_blank 0, RGB 0, out_hsync = !H_SYNC_POL, out_vsync = !V_SYNC_POL.
- Elaboration: $error if H_TOTAL-1 does not fit in X_WIDTH, if V_TOTAL-1 does not fit in Y_WIDTH, or if any width parameter is 0.

## Timing
- Latency from counter (x, y) to the output bundle for that dot = PIPE_DELAY + 1 enabled cycles.
- Source contract: inp_rgb for coordinate presented at enabled cycle n is valid at enabled cycle n + PIPE_DELAY.
- First enabled cycle after reset release: out_x = 0, out_y = 0, out_frame_start = 1. The first PIPE_DELAY + 1 outputs are the idle values.
- Reset asserted mid-frame aborts the frame with no end-of-frame completion; restart is at (0, 0).

## Structure
- Package video_pkg: timing struct (four H and four V widths), mode constants VGA_640x480 and SVGA_800x600, and total/sync-begin/sync-end helper functions.
- Sub-module video_delay: parameters WIDTH, DEPTH, RESET_VALUE; shift register with enable and asynchronous active-low reset. DEPTH = 0 is a wire.

## Test plan
- Defaults, enable tied 1, reset released -> frame_start at cycle 0; line period 800 clocks, frame 420000; out_hsync low for output cycles whose source x is 656..751 (appearing 3 clocks later); out_blank 1 for 640x480 dots per frame.
- PIPE_DELAY = 2, model source registers {x[7:0], y[7:0], 8'h5A} twice -> every active output has out_red = x and out_green = y of the dot counted 3 clocks earlier; blank and sync edges coincide with RGB edges.
- inp_enable toggling 1-of-2 -> counters and outputs advance only on enabled cycles; frame period 840000 clocks; strobes last 1 cycle.
- H_SYNC_POL = V_SYNC_POL = 1 -> sync pulses are high; outputs are low in reset and idle.
- Reset asserted asynchronously at x = 700, y = 100 -> outputs reach idle values before the next clock edge; after release, outputs restart at (0, 0) with frame_start.
- Tiny mode (H 4/1/2/1, V 3/1/1/1, PIPE_DELAY 0), inp_rgb held at 8'hFF -> exhaustive check of wrap at 8x6; RGB is 0 whenever out_blank is 0.
